uart_rx_byte: RTL
=================

// Module: uart_rx_byte
// PURPOSE
// - Serial UART receiver; front end of the DES datapath, directly upstream of the 8-to-64 byte collector.
// - Recovers 8N1 frames (8E1 with parity option) from the asynchronous rx pin.
// - Presents each byte on byte_out with a one-cycle rx_done strobe, which the collector consumes.
// PARAMETERS
// - CLK_FREQ_HZ   100_000_000  system clock frequency in Hz
// - BAUD_RATE     115_200      serial bit rate
// - OVERSAMPLE    16           sample ticks per bit; must be an even number >= 8
// - TICK_DIV = CLK_FREQ_HZ/(BAUD_RATE*OVERSAMPLE), computed as a localparam with integer truncation; must be >= 1.
// PORTS
// - clock       in   1  system clock; all logic is on the rising edge
// - reset       in   1  asynchronous, active-low reset
// - rx          in   1  serial line; asynchronous to clock; idles high
// - byte_out    out  8  last good received byte; bit 0 is the first data bit on the wire
// - rx_done     out  1  one-cycle strobe: byte_out is valid and was updated this cycle
// - frame_err   out  1  one-cycle strobe: stop bit sampled low; byte discarded
// - busy        out  1  high in every state except IDLE
// - parity_err  out  1  exists only with UART_RX_PARITY_EN; one-cycle strobe on parity mismatch
// BEHAVIOUR
// - Reset values: byte_out=0, rx_done=0, frame_err=0, parity_err=0, busy=0, FSM=IDLE, counters=0.
// - Synchronizer flops reset to 1 (line idle).
// - rx passes through a 2-flop synchronizer; all decisions use the synchronized value rx_s.
// - Tick generator: counter 0..TICK_DIV-1; emits a 1-clock tick on wrap.
// - The tick counter runs only while busy; it is cleared in IDLE.
// - FSM states: IDLE, START, DATA, [PARITY], STOP, WAIT_HIGH.
// - IDLE -> START when rx_s is 0 (falling edge from idle); tick and sample counters are cleared.
// - START: after OVERSAMPLE/2 ticks (mid-bit), sample rx_s.
//   - rx_s=1: false start; go to IDLE with no strobe.
//   - rx_s=0: go to DATA; tick counter reset.
// - DATA: every OVERSAMPLE ticks, sample rx_s into the shift register, LSB first.
//   - After 8 samples: go to PARITY if enabled, else STOP.
// - STOP: after OVERSAMPLE ticks, sample rx_s.
//   - rx_s=1: on the next clock, load byte_out and pulse rx_done for exactly 1 cycle; go to IDLE.
//   - rx_s=0: on the next clock, pulse frame_err for 1 cycle; byte_out unchanged; go to WAIT_HIGH.
// - WAIT_HIGH: stay until rx_s=1, then go to IDLE (prevents a break from re-triggering).
// - A new start is accepted in the IDLE cycle right after rx_done.
// - Back-to-back frames must be received without loss.
// - Latency: rx_done rises 2 sync clocks + 1 clock after the stop-bit mid-sample.
// - Only one of rx_done, frame_err and parity_err is ever high in a given cycle.
// - Reset asserted mid-frame: everything returns to reset values immediately; the partial byte is lost.
// - After reset, the first frame needs a high-to-low edge; a line held low at reset release waits in WAIT_HIGH-like fashion.
//   - Implementation: FSM enters IDLE, and IDLE requires a previous rx_s=1 before it accepts a start.
// CONFIGURATION
// - UART_RX_PARITY_EN defined:
//   - PARITY state samples a 9th bit, OVERSAMPLE ticks after the last data bit.
//   - Parity is even: XOR of data and parity bits must be 0.
//   - On mismatch, the FSM still checks the stop bit.
//     - Stop good: pulse parity_err (not rx_done); byte_out unchanged.
//     - Stop bad: frame_err takes priority.
//   - parity_err port is present.
// - UART_RX_PARITY_EN undefined:
//   - No PARITY state and no parity_err port.
//   - Frame is 10 bits (8N1).
// TESTING
// - Bench parameters: CLK_FREQ_HZ=1_600_000, BAUD_RATE=100_000, OVERSAMPLE=16 (TICK_DIV=1; bit = 16 clocks).
// - Send 0xA5 (8N1) -> rx_done high exactly 1 cycle; byte_out=0xA5; busy low afterwards; frame_err never high.
// - Send 8 frames back-to-back, 0x01..0x08, no idle gap -> 8 rx_done pulses; bytes in order; none dropped.
// - 4-clock low glitch on idle rx -> no rx_done and no frame_err; busy returns low at the START mid-sample (8 ticks).
// - Send 0x3C with the stop bit forced low, then line low for 40 clocks, then 0x55 ->
//   - frame_err pulse; byte_out stays at its prior value.
//   - No activity until the line goes high.
//   - Then rx_done with byte_out=0x55.
// - Assert reset during data bit 4 of 0xFF, release, send 0x12 -> outputs 0 during reset; next rx_done shows 0x12.
// - With UART_RX_PARITY_EN:
//   - 0x07 with parity bit 1 -> rx_done, byte_out=0x07.
//   - 0x07 with parity bit 0 -> parity_err pulse, no rx_done.

Source files
------------

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: oversampling UART receiver, 8N1 by default, 8E1 when UART_RX_PARITY_EN is defined
module uart_rx_byte #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD_RATE   = 115_200,
  parameter int OVERSAMPLE  = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] byte_out,
  output logic       rx_done,
  output logic       frame_err,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       busy
);
  localparam int TICK_DIV = CLK_FREQ_HZ / (BAUD_RATE * OVERSAMPLE);
  localparam int TW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam int SW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] HALF = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] LAST = SW'(OVERSAMPLE - 1);
`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;
  logic par_bad;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
`endif
  state_t state;
  logic rx_m, rx_s, armed;
  logic [1:0] vld;
  logic [TW-1:0] tick_cnt;
  logic [SW-1:0] s_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shift;
  logic tick;
  assign tick = tick_cnt == TICK_LAST;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_m      <= 1'b1;
      rx_s      <= 1'b1;
      vld       <= '0;
      armed     <= 1'b0;
      state     <= IDLE;
      tick_cnt  <= '0;
      s_cnt     <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      byte_out  <= '0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
      par_bad    <= 1'b0;
`endif
    end else begin
      rx_m      <= rx;
      rx_s      <= rx_m;
      vld       <= {vld[0], 1'b1};
      // a start is only honoured after a genuine high, not the reset value of the synchronizer
      armed     <= vld[1] & rx_s;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      tick_cnt  <= (state == IDLE || tick) ? '0 : tick_cnt + TW'(1);
      case (state)
        IDLE: if (armed && !rx_s) begin
          state    <= START;
          s_cnt    <= '0;
          tick_cnt <= '0;
          busy     <= 1'b1;
        end
        START: if (tick) begin
          if (s_cnt == HALF) begin
            s_cnt    <= '0;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            state    <= rx_s ? IDLE : DATA;
            busy     <= !rx_s;
          end else s_cnt <= s_cnt + SW'(1);
        end
        DATA: if (tick) begin
          if (s_cnt == LAST) begin
            s_cnt   <= '0;
            shift   <= {rx_s, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
`ifdef UART_RX_PARITY_EN
            if (bit_cnt == 3'd7) state <= PARITY;
`else
            if (bit_cnt == 3'd7) state <= STOP;
`endif
          end else s_cnt <= s_cnt + SW'(1);
        end
`ifdef UART_RX_PARITY_EN
        PARITY: if (tick) begin
          if (s_cnt == LAST) begin
            s_cnt   <= '0;
            par_bad <= ^{shift, rx_s};
            state   <= STOP;
          end else s_cnt <= s_cnt + SW'(1);
        end
`endif
        STOP: if (tick) begin
          if (s_cnt == LAST) begin
            s_cnt <= '0;
            if (!rx_s) begin
              frame_err <= 1'b1;
              state     <= WAIT_HIGH;
            end else begin
`ifdef UART_RX_PARITY_EN
              parity_err <= par_bad;
              rx_done    <= !par_bad;
              if (!par_bad) byte_out <= shift;
`else
              rx_done  <= 1'b1;
              byte_out <= shift;
`endif
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else s_cnt <= s_cnt + SW'(1);
        end
        WAIT_HIGH: if (rx_s) begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule
